// File: rtl/ttpu_pkg.sv
// Shared types for the TTPU processing-unit scheduler: fp16 word, scheduler states,
// operand pair payload and the fp16 quiet-NaN used for aborted results.
package ttpu_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } pu_sched_state_t;

  typedef struct packed {
    fp16_t a;
    fp16_t b;
  } operand_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/pu_scheduler_if.sv
// Requester-side bus of pu_scheduler: per-requester operand handshake plus the
// tagged result strobe. master = requesters/consumer, slave = scheduler.
interface pu_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import ttpu_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req_valid;
  fp16_t [NUM_REQ-1:0] req_a;
  fp16_t [NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]  req_ready;

  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  fp16_t               rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping
// to the lowest index. Produces one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // First pass covers [ptr, NUM_REQ-1]; second pass supplies the wrapped winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (ID_W'(i) >= ptr)) begin
        any      = 1'b1;
        idx      = ID_W'(i);
        grant[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        idx      = ID_W'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pu_scheduler.sv
// Round-robin scheduler sharing one fp16 processing_unit between NUM_REQ requesters.
// Optional WAIT timeout with qNaN/err result is enabled by defining PU_TIMEOUT_EN.
module pu_scheduler
  import ttpu_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  pu_scheduler_if.slave     bus,
  output logic              pu_start,
  output fp16_t             pu_a,
  output fp16_t             pu_b,
  input  fp16_t             pu_P,
  input  logic              pu_ready,
  output logic              busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("pu_scheduler: NUM_REQ must be within 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("pu_scheduler: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  pu_sched_state_t    state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_q;
  operand_t           op_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Acceptance is only offered in IDLE and never while reset is asserted.
  assign bus.req_ready = (state == IDLE && reset) ? grant : '0;
  assign pu_a          = op_q.a;
  assign pu_b          = op_q.b;

`ifdef PU_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wait_cnt;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      id_q          <= '0;
      op_q          <= '0;
      pu_start      <= 1'b0;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
`ifdef PU_TIMEOUT_EN
      bus.rsp_err   <= 1'b0;
      wait_cnt      <= '0;
`endif
    end else begin
      pu_start      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            op_q.a   <= bus.req_a[grant_idx];
            op_q.b   <= bus.req_b[grant_idx];
            id_q     <= grant_idx;
            pu_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef PU_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (pu_ready) begin
            bus.rsp_data  <= pu_P;
            bus.rsp_id    <= id_q;
            bus.rsp_valid <= 1'b1;
`ifdef PU_TIMEOUT_EN
            bus.rsp_err   <= 1'b0;
`endif
            state         <= RESP;
          end
`ifdef PU_TIMEOUT_EN
          // Give up after TIMEOUT_CYCLES consecutive WAIT cycles without completion.
          else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_data  <= FP16_QNAN;
            bus.rsp_id    <= id_q;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          ptr   <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_scheduler.sv
// Self-checking bench for pu_scheduler (NUM_REQ=4) with a behavioural fp16 PU stub
// and a transaction-level round-robin reference model; define PU_TIMEOUT_EN for the timeout case.
module tb_pu_scheduler;
  import ttpu_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic  clk;
  logic  reset;
  logic  pu_start;
  fp16_t pu_a, pu_b, pu_P;
  logic  pu_ready;
  logic  busy;

  pu_scheduler_if #(.NUM_REQ(N)) bus ();

  pu_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pu_start(pu_start), .pu_a(pu_a),
    .pu_b(pu_b), .pu_P(pu_P), .pu_ready(pu_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // fp16 multiply for normal operands (truncating), enough for the directed values
  function automatic fp16_t fp16_mul(fp16_t a, fp16_t b);
    logic [21:0] m;
    logic [9:0]  f;
    int          e;
    m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) begin e = e + 1; f = m[20:11]; end
    else       f = m[19:10];
    return {a[15] ^ b[15], 5'(e), f};
  endfunction

  function automatic fp16_t rand_fp16();
    return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  // PU stub: result `lat` cycles after the WAIT entry; never completes when dead
  int    lat  = 1;
  bit    dead = 1'b0;
  bit    noise = 1'b0;
  logic  stub_ready, stub_pend;
  int    stub_cnt;
  fp16_t stub_P, stub_a, stub_b;
  assign pu_P     = stub_P;
  assign pu_ready = stub_ready | noise;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stub_ready <= 1'b0; stub_pend <= 1'b0; stub_cnt <= 0; stub_P <= '0;
      stub_a <= '0; stub_b <= '0;
    end else begin
      stub_ready <= 1'b0;
      if (pu_start && !dead) begin
        if (lat == 0) begin stub_ready <= 1'b1; stub_P <= fp16_mul(pu_a, pu_b); end
        else begin stub_pend <= 1'b1; stub_cnt <= lat; stub_a <= pu_a; stub_b <= pu_b; end
      end else if (stub_pend) begin
        if (stub_cnt == 1) begin
          stub_ready <= 1'b1; stub_P <= fp16_mul(stub_a, stub_b); stub_pend <= 1'b0;
        end
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Reference model state (transaction level)
  bit    m_busy = 1'b0;
  int    m_g = 0, m_ptr = 0, m_start_cyc = 0, m_rsp_cyc = 0;
  fp16_t m_a, m_b, m_data;
  logic  m_err;
  int    drop_pending = -1;
  bit    rand_en = 1'b0;
  bit    [N-1:0] st_valid = '0;
  fp16_t st_a [N];
  fp16_t st_b [N];
  int    served_id[$];
  fp16_t served_data[$];
  logic  served_err[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic post(int i, fp16_t a, fp16_t b);
    st_valid[i] = 1'b1; st_a[i] = a; st_b[i] = b;
  endtask

  task automatic model_clear();
    m_busy = 1'b0; m_ptr = 0; m_rsp_cyc = 0; drop_pending = -1; st_valid = '0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model
  task automatic tick();
    int g;
    logic [N-1:0] er;
    bit exp_start, exp_rv;
    @(negedge clk);
    cyc++;
    if (m_busy && m_rsp_cyc != 0 && cyc > m_rsp_cyc) begin
      m_busy = 1'b0; m_ptr = (m_g + 1) % N;
    end
    if (drop_pending >= 0) begin bus.req_valid[drop_pending] = 1'b0; drop_pending = -1; end
    for (int i = 0; i < N; i++) begin
      if (st_valid[i]) begin
        bus.req_valid[i] = 1'b1; bus.req_a[i] = st_a[i]; bus.req_b[i] = st_b[i]; st_valid[i] = 1'b0;
      end else if (rand_en && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
        bus.req_valid[i] = 1'b1; bus.req_a[i] = rand_fp16(); bus.req_b[i] = rand_fp16();
      end
    end
    if (rand_en) begin
      lat   = $urandom_range(0, 4);
      noise = (!m_busy || cyc == m_start_cyc || cyc == m_rsp_cyc) && ($urandom_range(0, 2) == 0);
    end else noise = 1'b0;
    #1;
    g  = m_busy ? -1 : pick(bus.req_valid, m_ptr);
    er = (g >= 0) ? N'(1 << g) : '0;
    exp_start = m_busy && cyc == m_start_cyc;
    exp_rv    = m_busy && cyc == m_rsp_cyc;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("pu_start", 32'(pu_start), 32'(exp_start));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    if (exp_start) begin chk("pu_a", 32'(pu_a), 32'(m_a)); chk("pu_b", 32'(pu_b), 32'(m_b)); end
    if (exp_rv) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_g));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      served_id.push_back(int'(bus.rsp_id));
      served_data.push_back(bus.rsp_data);
      served_err.push_back(bus.rsp_err);
    end
    if (g >= 0) begin
      m_busy = 1'b1; m_g = g; m_start_cyc = cyc + 1; m_rsp_cyc = 0;
      m_a = bus.req_a[g]; m_b = bus.req_b[g]; m_err = 1'b0; drop_pending = g;
    end else if (m_busy && m_rsp_cyc == 0 && cyc > m_start_cyc) begin
      if (pu_ready) begin
        chk("pu_a_hold", 32'(pu_a), 32'(m_a));
        m_rsp_cyc = cyc + 1; m_data = pu_P; m_err = 1'b0;
      end
`ifdef PU_TIMEOUT_EN
      else if (cyc == m_start_cyc + TMO) begin
        m_rsp_cyc = cyc + 1; m_data = 16'h7E00; m_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic run_until(int n, int budget);
    int k = 0;
    while (served_id.size() < n && k < budget) begin tick(); k++; end
    chk("served_count", 32'(served_id.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    served_id.delete(); served_data.delete(); served_err.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0; bus.req_valid = '1; bus.req_a = '0; bus.req_b = '0;
    // 1: reset held low with all requests asserted
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_pu_start", 32'(pu_start), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    @(negedge clk);
    reset = 1'b1; bus.req_valid = '0;
    repeat (2) tick();

    // 2: single request from requester 0
    post(0, 16'h3C00, 16'h4000);
    run_until(1, 20);
    chk("t2_id", 32'(served_id[0]), 32'd0);
    chk("t2_data", 32'(served_data[0]), 32'h4000);

    // 3: all four at once, strict rotation from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) post(i, 16'h4400, 16'h4000);
    run_until(4, 100);
    for (int i = 0; i < N; i++) begin
      chk("t3_id", 32'(served_id[i]), 32'(i));
      chk("t3_data", 32'(served_data[i]), 32'h4800);
    end

    // 4: after serving 2, requests 1 and 3 -> 3 first, then wrap to 1
    do_reset();
    post(2, 16'h3C00, 16'h3C00);
    run_until(1, 20);
    post(1, 16'h4000, 16'h4000);
    post(3, 16'h4200, 16'h4000);
    run_until(3, 40);
    chk("t4_first", 32'(served_id[1]), 32'd3);
    chk("t4_second", 32'(served_id[2]), 32'd1);

    // 5: reset pulse while waiting on the PU
    do_reset();
    lat = 10;
    post(0, 16'h3C00, 16'h4000);
    k = 0;
    while (!(m_busy && cyc == m_start_cyc + 2) && k < 20) begin tick(); k++; end
    chk("t5_in_wait", 32'(m_busy && cyc == m_start_cyc + 2), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_pu_start", 32'(pu_start), 32'h0);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t5_pu_a", 32'(pu_a), 32'h0);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    served_id.delete(); served_data.delete(); served_err.delete();
    lat = 1;
    repeat (15) tick();
    chk("t5_no_rsp", 32'(served_id.size()), 32'd0);
    post(2, 16'h4000, 16'h4000);
    run_until(1, 20);
    chk("t5_id", 32'(served_id[0]), 32'd2);

`ifdef PU_TIMEOUT_EN
    // 6: PU never completes -> timeout result
    do_reset();
    dead = 1'b1;
    post(0, 16'h3C00, 16'h4000);
    run_until(1, 2 * TMO + 20);
    chk("t6_data", 32'(served_data[0]), 32'h7E00);
    chk("t6_err", 32'(served_err[0]), 32'd1);
    dead = 1'b0;
`endif

    // Randomized traffic with random PU latency and ignored-ready noise
    do_reset();
    rand_en = 1'b1;
    repeat (1500) tick();
    rand_en = 1'b0;
    k = 0;
    while ((bus.req_valid != '0 || m_busy) && k < 200) begin tick(); k++; end
    chk("drain", 32'({bus.req_valid, m_busy}), 32'h0);
    chk("rand_served", 32'(served_id.size() > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
